// File: rtl/ddr_line_engine.sv
// ddr_line_engine: moves one cache line between a local line buffer and a
// DDR burst controller.
//   Cache side : wb_wr_en/idx/data load the line buffer; wb_req writes it
//                back to wb_addr; fill_req fetches a line from fill_addr and
//                streams it out on fill_valid/fill_idx/fill_data. busy,
//                wb_done, fill_done and the sticky len_err report status.
//   DDR side   : rd_/wr_burst_req/len/addr issue bursts; wr_burst_data_req
//                pulls buffer beats onto wr_burst_data; rd_burst_data_valid
//                delivers read beats; *_burst_finish closes a burst.
//   clk with synchronous active-high rst.
module ddr_line_engine #(
   parameter int unsigned DDR_DATA_WIDTH = 128,
   parameter int unsigned DDR_ADDR_WIDTH = 28,
   parameter int unsigned LINE_BEATS     = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   // cache side
   input  logic                            wb_wr_en,
   input  logic [$clog2(LINE_BEATS)-1:0]   wb_wr_idx,
   input  logic [DDR_DATA_WIDTH-1:0]       wb_wr_data,
   input  logic                            wb_req,
   input  logic [DDR_ADDR_WIDTH-1:0]       wb_addr,
   input  logic                            fill_req,
   input  logic [DDR_ADDR_WIDTH-1:0]       fill_addr,
   output logic                            busy,
   output logic                            fill_valid,
   output logic [$clog2(LINE_BEATS)-1:0]   fill_idx,
   output logic [DDR_DATA_WIDTH-1:0]       fill_data,
   output logic                            wb_done,
   output logic                            fill_done,
   output logic                            len_err,
   // controller side
   output logic                            rd_burst_req,
   output logic                            wr_burst_req,
   output logic [9:0]                      rd_burst_len,
   output logic [9:0]                      wr_burst_len,
   output logic [DDR_ADDR_WIDTH-1:0]       rd_burst_addr,
   output logic [DDR_ADDR_WIDTH-1:0]       wr_burst_addr,
   input  logic                            rd_burst_data_valid,
   input  logic [DDR_DATA_WIDTH-1:0]       rd_burst_data,
   input  logic                            wr_burst_data_req,
   output logic [DDR_DATA_WIDTH-1:0]       wr_burst_data,
   input  logic                            rd_burst_finish,
   input  logic                            wr_burst_finish
);

   localparam int unsigned IDX_W = $clog2(LINE_BEATS);
   localparam int unsigned CNT_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WB_REQ,
      ST_FILL_REQ,
      ST_DONE
   } state_t;

   state_t                    r_state;
   logic                      r_wb_pend;
   logic                      r_fill_pend;
   logic [DDR_ADDR_WIDTH-1:0] r_wb_pend_addr;
   logic [DDR_ADDR_WIDTH-1:0] r_fill_pend_addr;
   logic [IDX_W-1:0]          r_wr_ptr;
   logic [CNT_W-1:0]          r_wr_cnt;
   logic [CNT_W-1:0]          r_rd_cnt;
   logic                      r_rd_req;
   logic                      r_wr_req;
   logic [DDR_ADDR_WIDTH-1:0] r_rd_addr;
   logic [DDR_ADDR_WIDTH-1:0] r_wr_addr;
   logic [DDR_DATA_WIDTH-1:0] r_wr_data;
   logic                      r_fill_valid;
   logic [IDX_W-1:0]          r_fill_idx;
   logic [DDR_DATA_WIDTH-1:0] r_fill_data;
   logic                      r_wb_done;
   logic                      r_fill_done;
   logic                      r_len_err;
   logic [DDR_DATA_WIDTH-1:0] r_buf [LINE_BEATS];

   logic                      w_idle;
   logic                      w_done_st;
   logic                      w_start_wb;
   logic                      w_start_fill;
   logic                      w_wb_latch;
   logic                      w_fill_direct;
   logic                      w_fill_latch;
   logic [DDR_ADDR_WIDTH-1:0] w_wb_addr_sel;
   logic [DDR_ADDR_WIDTH-1:0] w_fill_addr_sel;
   logic [CNT_W-1:0]          w_wr_beats;
   logic [CNT_W-1:0]          w_rd_beats;

   // Request arbitration: pending slots first, writeback over fill.
   // Incoming requests are taken directly only in IDLE; in DONE only the
   // pending slots can launch the next operation.
   assign w_idle        = (r_state == ST_IDLE);
   assign w_done_st     = (r_state == ST_DONE);
   assign w_start_wb    = (w_idle & (r_wb_pend | wb_req)) | (w_done_st & r_wb_pend);
   assign w_start_fill  = ~w_start_wb &
                          ((w_idle & (r_fill_pend | fill_req)) | (w_done_st & r_fill_pend));
   assign w_wb_latch    = wb_req & ~r_wb_pend & ~w_idle;
   assign w_fill_direct = fill_req & w_idle & ~r_fill_pend & ~w_start_wb;
   assign w_fill_latch  = fill_req & ~r_fill_pend & ~w_fill_direct;
   assign w_wb_addr_sel   = r_wb_pend   ? r_wb_pend_addr   : wb_addr;
   assign w_fill_addr_sel = r_fill_pend ? r_fill_pend_addr : fill_addr;

   // Beat totals including a strobe coincident with finish.
   assign w_wr_beats = r_wr_cnt + CNT_W'(wr_burst_data_req);
   assign w_rd_beats = r_rd_cnt + CNT_W'(rd_burst_data_valid);

   assign busy          = (r_state != ST_IDLE) | r_wb_pend | r_fill_pend;
   assign rd_burst_len  = CNT_W'(LINE_BEATS);
   assign wr_burst_len  = CNT_W'(LINE_BEATS);
   assign rd_burst_req  = r_rd_req;
   assign wr_burst_req  = r_wr_req;
   assign rd_burst_addr = r_rd_addr;
   assign wr_burst_addr = r_wr_addr;
   assign wr_burst_data = r_wr_data;
   assign fill_valid    = r_fill_valid;
   assign fill_idx      = r_fill_idx;
   assign fill_data     = r_fill_data;
   assign wb_done       = r_wb_done;
   assign fill_done     = r_fill_done;
   assign len_err       = r_len_err;

   // Line buffer; a same-cycle read sees the previous contents.
   always_ff @(posedge clk) begin
      if (wb_wr_en) begin
         r_buf[wb_wr_idx] <= wb_wr_data;
      end
   end

   // Control FSM with pending slots and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_wb_pend        <= 1'b0;
         r_fill_pend      <= 1'b0;
         r_wb_pend_addr   <= '0;
         r_fill_pend_addr <= '0;
         r_wr_ptr         <= '0;
         r_wr_cnt         <= '0;
         r_rd_cnt         <= '0;
         r_rd_req         <= 1'b0;
         r_wr_req         <= 1'b0;
         r_rd_addr        <= '0;
         r_wr_addr        <= '0;
         r_wr_data        <= '0;
         r_fill_valid     <= 1'b0;
         r_fill_idx       <= '0;
         r_fill_data      <= '0;
         r_wb_done        <= 1'b0;
         r_fill_done      <= 1'b0;
         r_len_err        <= 1'b0;
      end else begin
         r_fill_valid <= 1'b0;
         r_wb_done    <= 1'b0;
         r_fill_done  <= 1'b0;

         if (w_wb_latch) begin
            r_wb_pend      <= 1'b1;
            r_wb_pend_addr <= wb_addr;
         end else if (w_start_wb && r_wb_pend) begin
            r_wb_pend <= 1'b0;
         end

         if (w_fill_latch) begin
            r_fill_pend      <= 1'b1;
            r_fill_pend_addr <= fill_addr;
         end else if (w_start_fill && r_fill_pend) begin
            r_fill_pend <= 1'b0;
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_wb) begin
                  r_wr_addr <= w_wb_addr_sel;
                  r_wr_req  <= 1'b1;
                  r_wr_ptr  <= '0;
                  r_wr_cnt  <= '0;
                  r_state   <= ST_WB_REQ;
               end else if (w_start_fill) begin
                  r_rd_addr <= w_fill_addr_sel;
                  r_rd_req  <= 1'b1;
                  r_rd_cnt  <= '0;
                  r_state   <= ST_FILL_REQ;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WB_REQ: begin
               if (wr_burst_data_req) begin
                  r_wr_data <= r_buf[r_wr_ptr];
                  r_wr_ptr  <= r_wr_ptr + IDX_W'(1);
                  r_wr_cnt  <= r_wr_cnt + CNT_W'(1);
               end
               if (wr_burst_finish) begin
                  r_wr_req  <= 1'b0;
                  r_wb_done <= 1'b1;
                  if (w_wr_beats != CNT_W'(LINE_BEATS)) begin
                     r_len_err <= 1'b1;
                  end
                  r_state <= ST_DONE;
               end
            end
            ST_FILL_REQ: begin
               if (rd_burst_data_valid) begin
                  r_fill_valid <= 1'b1;
                  r_fill_data  <= rd_burst_data;
                  r_fill_idx   <= r_rd_cnt[IDX_W-1:0];
                  r_rd_cnt     <= r_rd_cnt + CNT_W'(1);
               end
               if (rd_burst_finish) begin
                  r_rd_req    <= 1'b0;
                  r_fill_done <= 1'b1;
                  if (w_rd_beats != CNT_W'(LINE_BEATS)) begin
                     r_len_err <= 1'b1;
                  end
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_line_engine.sv
// tb_ddr_line_engine: directed, table-driven bench for ddr_line_engine with
// a hand-driven DDR controller model.
module tb_ddr_line_engine;

   localparam int unsigned DW = 128;
   localparam int unsigned AW = 28;
   localparam int unsigned LB = 8;
   localparam int unsigned IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          wb_wr_en;
   logic [IW-1:0] wb_wr_idx;
   logic [DW-1:0] wb_wr_data;
   logic          wb_req;
   logic [AW-1:0] wb_addr;
   logic          fill_req;
   logic [AW-1:0] fill_addr;
   logic          busy;
   logic          fill_valid;
   logic [IW-1:0] fill_idx;
   logic [DW-1:0] fill_data;
   logic          wb_done;
   logic          fill_done;
   logic          len_err;
   logic          rd_burst_req;
   logic          wr_burst_req;
   logic [9:0]    rd_burst_len;
   logic [9:0]    wr_burst_len;
   logic [AW-1:0] rd_burst_addr;
   logic [AW-1:0] wr_burst_addr;
   logic          rd_burst_data_valid;
   logic [DW-1:0] rd_burst_data;
   logic          wr_burst_data_req;
   logic [DW-1:0] wr_burst_data;
   logic          rd_burst_finish;
   logic          wr_burst_finish;

   always #5 clk = ~clk;

   ddr_line_engine #(
      .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .LINE_BEATS(LB)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_wr_en(wb_wr_en), .wb_wr_idx(wb_wr_idx), .wb_wr_data(wb_wr_data),
      .wb_req(wb_req), .wb_addr(wb_addr),
      .fill_req(fill_req), .fill_addr(fill_addr),
      .busy(busy), .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
      .wb_done(wb_done), .fill_done(fill_done), .len_err(len_err),
      .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
      .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
      .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
      .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
      .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
      .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish)
   );

   typedef struct {
      logic [IW-1:0] slot;
      logic [DW-1:0] wdata;
   } wb_vec_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic [IW-1:0] exp_idx;
      logic [DW-1:0] exp_data;
   } fill_vec_t;

   wb_vec_t       wvec [LB];
   fill_vec_t     fvec [LB];
   logic [DW-1:0] exp_buf [LB];

   int n_checks = 0;
   int n_err = 0;
   int cnt_wb_done = 0;
   int cnt_fill_done = 0;

   // Done-pulse counters, sampled at the edge (outputs are registered).
   always @(posedge clk) begin
      if (wb_done === 1'b1) cnt_wb_done++;
      if (fill_done === 1'b1) cnt_fill_done++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic buf_write(input logic [IW-1:0] slot, input logic [DW-1:0] data);
      wb_wr_en   = 1'b1;
      wb_wr_idx  = slot;
      wb_wr_data = data;
      exp_buf[slot] = data;
      tick();
      wb_wr_en = 1'b0;
   endtask

   // Controller model for a writeback: n data requests, then finish.
   task automatic serve_wb(input int n, input logic [AW-1:0] exp_addr);
      int k = 0;
      while (wr_burst_req !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk("wr_req_rise", DW'(wr_burst_req), DW'(1));
      chk("wr_addr", DW'(wr_burst_addr), DW'(exp_addr));
      for (int i = 0; i < n; i++) begin
         wr_burst_data_req = 1'b1;
         tick();
         chk("wr_data", wr_burst_data, exp_buf[i % LB]);
         chk("rd_req_during_wb", DW'(rd_burst_req), DW'(0));
      end
      wr_burst_data_req = 1'b0;
      wr_burst_finish   = 1'b1;
      tick();
      wr_burst_finish = 1'b0;
      chk("wb_done_pulse", DW'(wb_done), DW'(1));
      chk("wr_req_after_finish", DW'(wr_burst_req), DW'(0));
      tick();
      chk("wb_done_single", DW'(wb_done), DW'(0));
   endtask

   // Controller model for a fill: n beats from the fill table, then finish.
   task automatic serve_fill(input int n, input logic [AW-1:0] exp_addr, input logic exp_err);
      int k = 0;
      while (rd_burst_req !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk("rd_req_rise", DW'(rd_burst_req), DW'(1));
      chk("rd_addr", DW'(rd_burst_addr), DW'(exp_addr));
      for (int i = 0; i < n; i++) begin
         rd_burst_data_valid = 1'b1;
         rd_burst_data       = fvec[i].rdata;
         tick();
         chk("fill_valid", DW'(fill_valid), DW'(1));
         chk("fill_idx", DW'(fill_idx), DW'(fvec[i].exp_idx));
         chk("fill_data", fill_data, fvec[i].exp_data);
      end
      rd_burst_data_valid = 1'b0;
      rd_burst_finish     = 1'b1;
      tick();
      rd_burst_finish = 1'b0;
      chk("fill_done_pulse", DW'(fill_done), DW'(1));
      chk("rd_req_after_finish", DW'(rd_burst_req), DW'(0));
      chk("fill_valid_at_done", DW'(fill_valid), DW'(0));
      chk("len_err_at_done", DW'(len_err), DW'(exp_err));
      tick();
      chk("fill_done_single", DW'(fill_done), DW'(0));
   endtask

   initial begin
      int wb0, fd0, k;
      logic saw_rd;

      // Vector tables: buffer written in reverse slot order; fill beats 0xA0+i.
      for (int i = 0; i < LB; i++) begin
         wvec[i].slot  = IW'(LB - 1 - i);
         wvec[i].wdata = DW'(32'h107 - i);
         fvec[i].rdata    = DW'(32'hA0 + i);
         fvec[i].exp_idx  = IW'(i);
         fvec[i].exp_data = DW'(32'hA0 + i);
      end

      rst = 1'b1;
      wb_wr_en = 1'b0; wb_wr_idx = '0; wb_wr_data = '0;
      wb_req = 1'b0; wb_addr = '0; fill_req = 1'b0; fill_addr = '0;
      rd_burst_data_valid = 1'b0; rd_burst_data = '0;
      wr_burst_data_req = 1'b0; rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state and constant burst lengths
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_wr_req", DW'(wr_burst_req), DW'(0));
      chk("rst_rd_req", DW'(rd_burst_req), DW'(0));
      chk("rst_len_err", DW'(len_err), DW'(0));
      chk("rst_fill_valid", DW'(fill_valid), DW'(0));
      chk("rst_wr_addr", DW'(wr_burst_addr), DW'(0));
      chk("rst_fill_data", fill_data, DW'(0));
      chk("rd_len", DW'(rd_burst_len), DW'(8));
      chk("wr_len", DW'(wr_burst_len), DW'(8));

      // Controller strobes in IDLE are ignored
      rd_burst_finish = 1'b1; wr_burst_finish = 1'b1;
      rd_burst_data_valid = 1'b1; wr_burst_data_req = 1'b1;
      rd_burst_data = DW'(32'hDEAD);
      tick();
      rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
      rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
      chk("idle_busy", DW'(busy), DW'(0));
      chk("idle_fill_valid", DW'(fill_valid), DW'(0));
      chk("idle_wb_done", DW'(wb_done), DW'(0));
      chk("idle_fill_done", DW'(fill_done), DW'(0));
      chk("idle_len_err", DW'(len_err), DW'(0));

      // Writeback of 0x100..0x107 to 0x40
      for (int i = 0; i < LB; i++) buf_write(wvec[i].slot, wvec[i].wdata);
      wb0 = cnt_wb_done;
      wb_req = 1'b1; wb_addr = AW'(32'h40);
      tick();
      wb_req = 1'b0;
      chk("wb_busy", DW'(busy), DW'(1));
      serve_wb(8, AW'(32'h40));
      chk("wb_idle_busy", DW'(busy), DW'(0));
      chk("wb_done_count", DW'(cnt_wb_done - wb0), DW'(1));

      // Fill from 0x200
      fd0 = cnt_fill_done;
      fill_req = 1'b1; fill_addr = AW'(32'h200);
      tick();
      fill_req = 1'b0;
      serve_fill(8, AW'(32'h200), 1'b0);
      chk("fill_idle_busy", DW'(busy), DW'(0));
      chk("fill_done_count", DW'(cnt_fill_done - fd0), DW'(1));

      // Simultaneous wb_req and fill_req: writeback first, then the fill
      buf_write(IW'(2), DW'(32'h5555));
      wb0 = cnt_wb_done; fd0 = cnt_fill_done;
      wb_req = 1'b1; wb_addr = AW'(32'hC0);
      fill_req = 1'b1; fill_addr = AW'(32'h400);
      tick();
      wb_req = 1'b0; fill_req = 1'b0;
      chk("both_rd_req_low", DW'(rd_burst_req), DW'(0));
      serve_wb(8, AW'(32'hC0));
      chk("both_wb_done_first", DW'(cnt_wb_done - wb0), DW'(1));
      chk("both_no_fill_done_yet", DW'(cnt_fill_done - fd0), DW'(0));
      serve_fill(8, AW'(32'h400), 1'b0);
      chk("both_wb_done_count", DW'(cnt_wb_done - wb0), DW'(1));
      chk("both_fill_done_count", DW'(cnt_fill_done - fd0), DW'(1));
      chk("both_idle", DW'(busy), DW'(0));

      // Short read: finish after 6 beats sets sticky len_err
      fd0 = cnt_fill_done;
      fill_req = 1'b1; fill_addr = AW'(32'h240);
      tick();
      fill_req = 1'b0;
      serve_fill(6, AW'(32'h240), 1'b1);
      chk("short_fill_done_count", DW'(cnt_fill_done - fd0), DW'(1));

      // Two fill_req pulses during a writeback: only one fill performed
      wb0 = cnt_wb_done; fd0 = cnt_fill_done;
      wb_req = 1'b1; wb_addr = AW'(32'h80);
      tick();
      wb_req = 1'b0;
      fill_req = 1'b1; fill_addr = AW'(32'h300);
      tick();
      fill_req = 1'b0;
      tick();
      fill_req = 1'b1; fill_addr = AW'(32'h340);
      tick();
      fill_req = 1'b0;
      serve_wb(8, AW'(32'h80));
      serve_fill(8, AW'(32'h300), 1'b1);
      saw_rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rd_burst_req === 1'b1) saw_rd = 1'b1;
      end
      chk("drop_no_second_fill", DW'(saw_rd), DW'(0));
      chk("drop_fill_done_count", DW'(cnt_fill_done - fd0), DW'(1));
      chk("drop_wb_done_count", DW'(cnt_wb_done - wb0), DW'(1));
      chk("drop_idle", DW'(busy), DW'(0));
      chk("len_err_sticky", DW'(len_err), DW'(1));

      // Reset on the 3rd fill beat abandons the fill
      fd0 = cnt_fill_done;
      fill_req = 1'b1; fill_addr = AW'(32'h500);
      tick();
      fill_req = 1'b0;
      k = 0;
      while (rd_burst_req !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      chk("rst_mid_rd_req", DW'(rd_burst_req), DW'(1));
      for (int i = 0; i < 2; i++) begin
         rd_burst_data_valid = 1'b1;
         rd_burst_data       = fvec[i].rdata;
         tick();
         chk("rst_mid_fill_idx", DW'(fill_idx), DW'(fvec[i].exp_idx));
      end
      rd_burst_data_valid = 1'b1;
      rd_burst_data       = fvec[2].rdata;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rd_burst_data_valid = 1'b0;
      chk("rst_mid_rd_req_low", DW'(rd_burst_req), DW'(0));
      chk("rst_mid_busy", DW'(busy), DW'(0));
      chk("rst_mid_fill_valid", DW'(fill_valid), DW'(0));
      chk("rst_mid_fill_data", fill_data, DW'(0));
      chk("rst_mid_len_err", DW'(len_err), DW'(0));
      for (int i = 0; i < 4; i++) tick();
      chk("rst_mid_no_done", DW'(cnt_fill_done - fd0), DW'(0));

      // A new fill after the reset completes normally
      fill_req = 1'b1; fill_addr = AW'(32'h600);
      tick();
      fill_req = 1'b0;
      serve_fill(8, AW'(32'h600), 1'b0);
      chk("post_rst_fill_done", DW'(cnt_fill_done - fd0), DW'(1));
      chk("post_rst_idle", DW'(busy), DW'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/ddr_line_engine.md
DDR_LINE_ENGINE -- requirements
Module: ddr_line_engine

Interface
REQ-001 SHALL have parameters: DDR_DATA_WIDTH, default 128, beat width; DDR_ADDR_WIDTH, default 28, DDR address width; LINE_BEATS, default 8 (power of two, 2..64), beats per cache line.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-003 Cache-side ports SHALL be:
- wb_wr_en  in  1  line-buffer write strobe.
- wb_wr_idx  in  log2(LINE_BEATS)  buffer slot.
- wb_wr_data  in  DDR_DATA_WIDTH  buffer data.
- wb_req  in  1  write back buffer to wb_addr, pulse.
- wb_addr  in  DDR_ADDR_WIDTH  line base.
- fill_req  in  1  fetch line from fill_addr, pulse.
- fill_addr  in  DDR_ADDR_WIDTH  line base.
- busy  out  1  operation in progress.
- fill_valid  out  1  fill beat strobe.
- fill_idx  out  log2(LINE_BEATS)  beat index.
- fill_data  out  DDR_DATA_WIDTH  beat data.
- wb_done  out  1  pulse.
- fill_done  out  1  pulse.
- len_err  out  1  sticky beat-count error.
REQ-004 Controller-side ports SHALL be:
- rd_burst_req, wr_burst_req  out  1.
- rd_burst_len, wr_burst_len  out  10.
- rd_burst_addr, wr_burst_addr  out  DDR_ADDR_WIDTH.
- rd_burst_data_valid  in  1.
- rd_burst_data  in  DDR_DATA_WIDTH.
- wr_burst_data_req  in  1.
- wr_burst_data  out  DDR_DATA_WIDTH.
- rd_burst_finish, wr_burst_finish  in  1.

Function
REQ-005 SHALL drive rd_burst_len and wr_burst_len constantly at LINE_BEATS.
REQ-006 SHALL implement states IDLE, WB_REQ, FILL_REQ, DONE.
REQ-007 IDLE: wb_req SHALL take priority over fill_req when both are sampled in the same cycle; the losing fill_req SHALL be latched (pending flag plus address) and serviced immediately after the writeback completes.
REQ-008 Requests SHALL be accepted only in IDLE; wb_req/fill_req arriving while busy=1 SHALL be latched into a one-deep pending slot per type; a second arrival of the same type while its slot is full SHALL be dropped.
REQ-009 On acceptance, SHALL register the address onto wr_burst_addr/rd_burst_addr and assert wr_burst_req/rd_burst_req from the next cycle.
REQ-010 The request SHALL be held high until the matching *_finish is sampled, and SHALL be 0 in the cycle after finish.
REQ-011 WB_REQ: on each cycle with wr_burst_data_req=1, SHALL load wr_burst_data <= buffer[wr_ptr] and increment wr_ptr (mod LINE_BEATS), so data appears one cycle after each request.
REQ-012 wr_ptr SHALL reset to 0 on acceptance of each writeback.
REQ-013 FILL_REQ: each cycle with rd_burst_data_valid=1 SHALL produce, on the next cycle, fill_valid=1, fill_data=rd_burst_data and fill_idx=rd_cnt, then increment rd_cnt.
REQ-014 rd_cnt SHALL reset to 0 on acceptance of each fill.
REQ-015 On the *_finish cycle SHALL go to DONE; DONE SHALL last one cycle, pulse wb_done or fill_done, and return to IDLE or directly to a pending request.
REQ-016 Beat count checks at finish:
- If rd_burst_finish is sampled with beat count (including the current beat) != LINE_BEATS, SHALL set len_err.
- If wr_burst_finish is sampled with wr_ptr-driven beats != LINE_BEATS, SHALL set len_err.
- len_err SHALL be cleared only by rst.
REQ-017 Line buffer: wb_wr_en SHALL write wb_wr_data to slot wb_wr_idx in any state.
REQ-018 Line-buffer write collisions: a write to a slot in the same cycle it is read for wr_burst_data SHALL return the old contents; writes during WB_REQ are cache misuse and are not otherwise protected.
REQ-019 busy SHALL be 1 in any state other than IDLE and also when a pending slot is non-empty.
REQ-020 *_finish or data strobes arriving in IDLE SHALL be ignored without state change.

Reset
REQ-021 On rst=1 at a clock edge SHALL force:
- state=IDLE.
- All req/valid/done outputs 0; len_err=0.
- Pending slots cleared; wr_ptr=0, rd_cnt=0.
- rd_burst_addr, wr_burst_addr, wr_burst_data, fill_data, fill_idx = 0.
REQ-022 Reset mid-burst SHALL abandon the operation with no done pulse; line-buffer contents need not be cleared.

Verification
REQ-023 Write slots 0..7 with 0x100+i, pulse wb_req with wb_addr=0x40 -> wr_burst_req=1 with wr_burst_addr=0x40; the eight wr_burst_data_req beats see 0x100..0x107 each one cycle later; after wr_burst_finish, wb_done pulses once.
REQ-024 fill_req with fill_addr=0x200, model returns 0xA0..0xA7 -> fill_valid ×8 with fill_idx 0..7 and matching data; fill_done pulses; len_err=0.
REQ-025 wb_req and fill_req in the same cycle -> the complete writeback burst precedes rd_burst_req; exactly one wb_done then one fill_done.
REQ-026 Model finishes the read after 6 beats -> len_err=1, fill_done still pulses, len_err persists until rst.
REQ-027 rst asserted on the 3rd fill beat -> next cycle rd_burst_req=0, busy=0, no fill_done; a new fill_req then completes normally.
REQ-028 Two fill_req pulses while a writeback is busy -> only one fill is performed (second dropped).
